// File: rtl/mash_out_gen_p_if.sv
// rtl/mash_out_gen_p_if.sv - integer/noise input and divider-word output bundle for mash_out_gen_p
interface mash_out_gen_p_if #(
    parameter int P_INT_W   = 8,
    parameter int P_NOISE_W = 4
);
    logic [P_INT_W-1:0]   i_int;
    logic [P_NOISE_W-1:0] i_noise;
    logic                 i_noise_vld;
    logic [P_INT_W-1:0]   o_div;
    logic                 o_div_vld;
    logic                 o_sat;

    // Source side: the MASH core and integer-word provider, which also observes the divider word
    modport master (
        output i_int,
        output i_noise,
        output i_noise_vld,
        input  o_div,
        input  o_div_vld,
        input  o_sat
    );

    // Output stage side
    modport slave (
        input  i_int,
        input  i_noise,
        input  i_noise_vld,
        output o_div,
        output o_div_vld,
        output o_sat
    );
endinterface

// File: rtl/mash_out_gen_p.sv
// rtl/mash_out_gen_p.sv - MASH output stage: align integer, add noise, clamp, register, count clamps
module mash_out_gen_p #(
    parameter int P_INT_W     = 8,
    parameter int P_NOISE_W   = 4,
    parameter int P_ALIGN_DLY = 1,
    parameter int P_OUT_MIN   = 0,
    parameter int P_OUT_MAX   = 255,
    parameter int P_CNT_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_bypass,
    input  logic               i_cnt_clr,
    mash_out_gen_p_if.slave    s_if,
    output logic               o_sat_sticky,
    output logic [P_CNT_W-1:0] o_sat_cnt
);
    // Two guard bits: one for the unsigned-to-signed extension, one so int + noise never wraps
    localparam int SW = P_INT_W + 2;
    localparam logic signed [SW-1:0]    S_MIN   = SW'(P_OUT_MIN);
    localparam logic signed [SW-1:0]    S_MAX   = SW'(P_OUT_MAX);
    localparam logic [P_INT_W-1:0]      D_MIN   = P_INT_W'(P_OUT_MIN);
    localparam logic [P_INT_W-1:0]      D_MAX   = P_INT_W'(P_OUT_MAX);
    localparam logic [P_CNT_W-1:0]      CNT_TOP = {P_CNT_W{1'b1}};

    logic [P_INT_W-1:0]     int_al;
    logic signed [SW-1:0]   sum;
    logic [P_INT_W-1:0]     clamp_val;
    logic                   clamped;
    logic                   upd;

    logic [P_INT_W-1:0]     div_q, div_d;
    logic                   div_vld_q, div_vld_d;
    logic                   sat_q, sat_d;
    logic                   sticky_q, sticky_d;
    logic [P_CNT_W-1:0]     cnt_q, cnt_d;

    // Integer alignment delay line; advances only on enabled cycles so it tracks the MASH pipeline
    generate
        if (P_ALIGN_DLY == 0) begin : g_nodly
            assign int_al = s_if.i_int;
        end else begin : g_dly
            logic [P_INT_W-1:0] dly_q [P_ALIGN_DLY];
            logic [P_INT_W-1:0] dly_d [P_ALIGN_DLY];

            // Next-state of the shift register: shift on enable, otherwise hold
            always_comb begin
                for (int i = 0; i < P_ALIGN_DLY; i++) begin
                    dly_d[i] = dly_q[i];
                end
                if (i_en) begin
                    dly_d[0] = s_if.i_int;
                    for (int i = 1; i < P_ALIGN_DLY; i++) begin
                        dly_d[i] = dly_q[i-1];
                    end
                end
            end

            // Delay-line registers, cleared by reset so the first words after release are zero
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < P_ALIGN_DLY; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < P_ALIGN_DLY; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign int_al = dly_q[P_ALIGN_DLY-1];
        end
    endgenerate

    // Add sign-extended noise and limit the result to the legal divider range
    always_comb begin
        sum = $signed({2'b00, int_al})
            + $signed({{(SW-P_NOISE_W){s_if.i_noise[P_NOISE_W-1]}}, s_if.i_noise});
        clamped   = 1'b0;
        clamp_val = sum[P_INT_W-1:0];
        if (sum < S_MIN) begin
            clamp_val = D_MIN;
            clamped   = 1'b1;
        end else if (sum > S_MAX) begin
            clamp_val = D_MAX;
            clamped   = 1'b1;
        end
    end

    // Output word, strobe, saturation flag and clamp statistics
    always_comb begin
        upd       = i_en & s_if.i_noise_vld;
        div_vld_d = upd;
        div_d     = div_q;
        sat_d     = 1'b0;
        // A clear in the same cycle as a clamp event is applied first, so the event still counts
        cnt_d     = i_cnt_clr ? '0 : cnt_q;
        sticky_d  = i_cnt_clr ? 1'b0 : sticky_q;
        if (upd) begin
            div_d = i_bypass ? int_al : clamp_val;
            sat_d = ~i_bypass & clamped;
            if (~i_bypass & clamped) begin
                sticky_d = 1'b1;
                if (cnt_d != CNT_TOP) begin
                    cnt_d = cnt_d + P_CNT_W'(1);
                end
            end
        end
    end

    // Output and status registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q     <= '0;
            div_vld_q <= 1'b0;
            sat_q     <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            div_q     <= div_d;
            div_vld_q <= div_vld_d;
            sat_q     <= sat_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_if.o_div     = div_q;
    assign s_if.o_div_vld = div_vld_q;
    assign s_if.o_sat     = sat_q;
    assign o_sat_sticky   = sticky_q;
    assign o_sat_cnt      = cnt_q;
endmodule

// File: tb/tb_mash_out_gen_p.sv
// tb/tb_mash_out_gen_p.sv - directed scoreboard bench for mash_out_gen_p
module tb_mash_out_gen_p;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic       i_bypass = 1'b0;
    logic       i_cnt_clr = 1'b0;
    logic       o_sat_sticky;
    logic [7:0] o_sat_cnt;

    mash_out_gen_p_if #(.P_INT_W(8), .P_NOISE_W(4)) bus ();

    mash_out_gen_p #(
        .P_INT_W(8), .P_NOISE_W(4), .P_ALIGN_DLY(1),
        .P_OUT_MIN(0), .P_OUT_MAX(255), .P_CNT_W(8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_bypass     (i_bypass),
        .i_cnt_clr    (i_cnt_clr),
        .s_if         (bus.slave),
        .o_sat_sticky (o_sat_sticky),
        .o_sat_cnt    (o_sat_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int div;
        int vld;
        int sat;
        int cnt;
        int sticky;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: one-stage integer delay, held output word, clamp counter
    int m_dly = 0;
    int m_div = 0;
    int m_cnt = 0;
    int m_sticky = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_dly = 0; m_div = 0; m_cnt = 0; m_sticky = 0;
    endtask

    // Drive one cycle of stimulus, predict the registered result, then compare after the edge
    task automatic step(input int iv, input int nz, input bit vld, input bit en,
                        input bit byp, input bit clr, input string tag);
        exp_t e;
        exp_t g;
        int   s;
        int   cv;
        bit   cl;
        int   n4;
        logic [3:0] nbits;
        nbits = 4'(nz);
        bus.i_int       = 8'(iv);
        bus.i_noise     = nbits;
        bus.i_noise_vld = vld;
        i_en            = en;
        i_bypass        = byp;
        i_cnt_clr       = clr;
        n4 = nbits[3] ? int'(nbits) - 16 : int'(nbits);
        s  = m_dly + n4;
        cl = 1'b0;
        cv = s;
        if (s < 0)   begin cv = 0;   cl = 1'b1; end
        if (s > 255) begin cv = 255; cl = 1'b1; end
        if (clr) begin m_cnt = 0; m_sticky = 0; end
        e.sat = 0;
        e.vld = (en && vld) ? 1 : 0;
        if (en && vld) begin
            m_div = byp ? m_dly : cv;
            if (!byp && cl) begin
                e.sat = 1;
                m_sticky = 1;
                if (m_cnt != 255) m_cnt = m_cnt + 1;
            end
        end
        if (en) m_dly = iv;
        e.div = m_div;
        e.cnt = m_cnt;
        e.sticky = m_sticky;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        if (exp_q.size() != 0) begin
            g = exp_q.pop_front();
            chk({tag, ".div"},    int'(bus.o_div),     g.div);
            chk({tag, ".vld"},    int'(bus.o_div_vld), g.vld);
            chk({tag, ".sat"},    int'(bus.o_sat),     g.sat);
            chk({tag, ".cnt"},    int'(o_sat_cnt),     g.cnt);
            chk({tag, ".sticky"}, int'(o_sat_sticky),  g.sticky);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".div"},    int'(bus.o_div),     0);
        chk({tag, ".vld"},    int'(bus.o_div_vld), 0);
        chk({tag, ".sat"},    int'(bus.o_sat),     0);
        chk({tag, ".cnt"},    int'(o_sat_cnt),     0);
        chk({tag, ".sticky"}, int'(o_sat_sticky),  0);
    endtask

    initial begin
        bus.i_int = '0;
        bus.i_noise = '0;
        bus.i_noise_vld = 1'b0;
        @(posedge i_clk);
        #1;
        chk_zero("reset");
        i_rst_n = 1'b1;
        model_reset();

        // Basic add with alignment priming
        step(100, 0, 0, 1, 0, 0, "prime100");
        step(100, -3, 1, 1, 0, 0, "t1_97");
        step(100, 0, 1, 1, 0, 0, "t2_100a");
        step(120, 0, 1, 1, 0, 0, "t2_100b");
        step(120, 0, 1, 1, 0, 0, "t2_120");

        // Upper and lower clamp
        step(254, 0, 0, 1, 0, 0, "prime254");
        step(254, 7, 1, 1, 0, 0, "t3_hi");
        step(2, -8, 1, 1, 0, 0, "t3_246");
        step(2, -8, 1, 1, 0, 0, "t3_lo");

        // Valid low with enable high: output holds, delay line still shifts
        step(77, 5, 0, 1, 0, 0, "novld");
        step(77, 1, 1, 1, 0, 0, "after_novld");

        // Bypass ignores noise and clamp
        step(254, 0, 1, 1, 1, 0, "byp_prime");
        step(254, 7, 1, 1, 1, 0, "t5_byp");

        // Enable low freezes everything
        for (int i = 0; i < 5; i++) begin
            step(50 + i, 3, 1, 0, 0, 0, "t5_frozen");
        end
        step(60, 0, 1, 1, 0, 0, "t5_thaw");

        // Saturating counter
        step(254, 0, 0, 1, 0, 0, "prime_sat");
        for (int i = 0; i < 300; i++) begin
            step(254, 7, 1, 1, 0, 0, "t4_sat");
        end
        step(254, 7, 1, 1, 0, 1, "t4_clr_clamp");
        step(254, 7, 0, 0, 0, 1, "clr_noen");
        step(254, 7, 1, 1, 0, 0, "recount");

        // Asynchronous reset mid-cycle
        #3;
        i_rst_n = 1'b0;
        #1;
        chk_zero("t6_async");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
        step(10, -2, 1, 1, 0, 0, "t6_first");
        step(10, 5, 1, 1, 0, 0, "t6_second");

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
